// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] c_r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
      $error("seq_restoring_divider: WIDTH must be in 2..64");
    end
  endgenerate

  // FINISH is the post-iteration cycle in which the result is formed;
  // DONE is the single cycle in which done is high.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic             zero_reg, zero_next;
  logic [WIDTH-1:0] q_out_reg, q_out_next;
  logic [WIDTH-1:0] r_out_reg, r_out_next;
  logic             dbz_reg, dbz_next;

  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   divisor_ext;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

`ifdef SIGNED_DIV_EN
  logic neg_q_reg, neg_q_next;
  logic neg_r_reg, neg_r_next;

  always_comb begin
    a_mag      = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag      = b[WIDTH-1] ? (~b + 1'b1) : b;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    if (accept) begin
      neg_q_next = a[WIDTH-1] ^ b[WIDTH-1];
      neg_r_next = a[WIDTH-1];
    end
  end

  // Truncation toward zero: quotient sign from the operand signs, remainder follows a.
  always_comb begin
    q_res = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
    r_res = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
    end
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
    q_res = dvd_reg;
    r_res = rem_reg;
  end
`endif

  assign accept = (state_reg == IDLE) && start;

  // Partial remainder shifted left by one with the next dividend bit appended.
  always_comb begin
    trial       = {rem_reg, dvd_reg[WIDTH-1]};
    divisor_ext = {1'b0, div_reg};
    diff        = trial - divisor_ext;
    fits        = (trial >= divisor_ext);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    dvd_next   = dvd_reg;
    div_next   = div_reg;
    a_next     = a_reg;
    zero_next  = zero_reg;
    q_out_next = q_out_reg;
    r_out_next = r_out_reg;
    dbz_next   = dbz_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next    = a;
          div_next  = b_mag;
          rem_next  = '0;
          dvd_next  = a_mag;
          cnt_next  = '0;
          zero_next = (b == '0);
          dbz_next  = 1'b0;
          state_next = (b == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (fits) begin
          rem_next = diff[WIDTH-1:0];
          dvd_next = {dvd_reg[WIDTH-2:0], 1'b1};
        end else begin
          rem_next = trial[WIDTH-1:0];
          dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        if (zero_reg) begin
          q_out_next = '1;
          r_out_next = a_reg;
          dbz_next   = 1'b1;
        end else begin
          q_out_next = q_res;
          r_out_next = r_res;
          dbz_next   = 1'b0;
        end
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      div_reg   <= '0;
      a_reg     <= '0;
      zero_reg  <= 1'b0;
      q_out_reg <= '0;
      r_out_reg <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      dvd_reg   <= dvd_next;
      div_reg   <= div_next;
      a_reg     <= a_next;
      zero_reg  <= zero_next;
      q_out_reg <= q_out_next;
      r_out_reg <= r_out_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign c_q         = q_out_reg;
  assign c_r         = r_out_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed and random divisions
// compared against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] c_q;
  logic [W-1:0] c_r;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .c_q        (c_q),
    .c_r        (c_r),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient/remainder by plain arithmetic.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic edz);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (tb_v == '0) begin
      eq  = '1;
      er  = ta;
      edz = 1'b1;
    end else begin
      edz = 1'b0;
`ifdef SIGNED_DIV_EN
      sa = $signed(ta);
      sb = $signed(tb_v);
      sq = sa / sb;
      sr = sa % sb;
      eq = sq[W-1:0];
      er = sr[W-1:0];
`else
      ua = ta;
      ub = tb_v;
      uq = ua / ub;
      ur = ua % ub;
      eq = uq[W-1:0];
      er = ur[W-1:0];
`endif
    end
  endtask

  // One operation; inject_at > 0 pulses a competing start before that edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input int inject_at, input string tag);
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat, busy_cnt;
    bit           seen;
    model(ta, tb_v, eq, er, edz);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    busy_cnt = int'(busy);
    lat = 0;
    seen = 0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      if (n == inject_at) begin
        a = 32'd9; b = 32'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1;
        lat = n;
      end else begin
        busy_cnt += int'(busy);
      end
    end
    check({tag, " latency"}, 64'(lat), (tb_v == '0) ? 64'd1 : 64'(W + 1));
    check({tag, " busy_cycles"}, 64'(busy_cnt), (tb_v == '0) ? 64'd0 : 64'(W));
    check({tag, " c_q"}, 64'(c_q), 64'(eq));
    check({tag, " c_r"}, 64'(c_r), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " hold_q"}, 64'(c_q), 64'(eq));
    check({tag, " hold_r"}, 64'(c_r), 64'(er));
    $display("op %s: a=%0h b=%0h -> q=%0h r=%0h dbz=%0b latency=%0d", tag, ta, tb_v, c_q, c_r, div_by_zero, lat);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset c_q", 64'(c_q), 64'd0);
    check("reset c_r", 64'(c_r), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 0, "100/7");
    run_op(32'd5, 32'd0, 0, "5/0");
    run_op(32'd3, 32'd10, 0, "3/10");
    run_op(32'hFFFF_FFFF, 32'd1, 0, "max/1");
    run_op(32'd100, 32'd7, 10, "ignore_start");

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset c_q", 64'(c_q), 64'd0);
    check("midreset c_r", 64'(c_r), 64'd0);
    check("midreset dbz", 64'(div_by_zero), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midreset done", 64'(done), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(posedge clk); #1;
      check("aborted no_done", 64'(done), 64'd0);
    end
    run_op(32'd1000, 32'd3, 0, "1000/3");

`ifdef SIGNED_DIV_EN
    run_op(32'hFFFF_FFF9, 32'd2, 0, "s -7/2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, "s min/-1");
    run_op(32'hFFFF_FFF9, 32'd0, 0, "s -7/0");
    run_op(32'd7, 32'hFFFF_FFFE, 0, "s 7/-2");
`endif

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
